spad_hit_collector: RTL and testbench

SPAD_HIT_COLLECTOR -- requirements
Module: spad_hit_collector

---
 rtl/spad_pkg.sv | 27 ++
 rtl/spad_sync2.sv | 28 ++
 rtl/spad_hit_collector.sv | 221 ++++++++++++++++++++++
 tb/tb_spad_hit_collector.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spad_pkg.sv
// Shared definitions for the SPAD hit collector.
//   CNT_W_DEFAULT : default coarse-counter width (512 cycles of 4 ns)
//   WIN_LAST      : last coarse count of a window at the default width
//   spad_state_e  : collector FSM states
//   hit_rec_t     : one buffered hit record
package spad_pkg;

  localparam int unsigned CNT_W_DEFAULT = 9;
  localparam int unsigned WIN_LAST      = (1 << CNT_W_DEFAULT) - 1;

  // The record time field is sized for the widest supported counter (CNT_W <= 16).
  localparam int unsigned HIT_TIME_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StDrain,
    StDone
  } spad_state_e;

  typedef struct packed {
    logic [HIT_TIME_W-1:0] time_cnt;
    logic [15:0]           intensity;
    logic [1:0]            idx;
  } hit_rec_t;

endpackage

// File: rtl/spad_sync2.sv
// Two-flop synchronizer with asynchronous active-high clear.
//   clk_250M : destination clock
//   rst_auto : asynchronous clear, active-high
//   din      : asynchronous input level
//   dout     : synchronized level (2 cycles of latency)
module spad_sync2 (
  input  logic clk_250M,
  input  logic rst_auto,
  input  logic din,
  output logic dout
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/spad_hit_collector.sv
// SPAD hit collector: time-stamps photon gates inside a coarse window opened by the TDC
// start level and buffers the records in a small show-ahead FIFO.
//   clk_250M   : sole clock
//   rst_auto   : asynchronous reset, active-high
//   TDC_start  : async window-start level
//   trig       : async first-photon flag (lost-gate recovery only)
//   time_gate  : async per-photon pulse
//   spad_int   : photon intensity word
//   hit_ready  : consumer ready
//   hit_valid  : head record available
//   hit_time   : coarse count of the head record
//   hit_int    : intensity of the head record
//   hit_idx    : ordinal of the head record in the window (saturates at 3)
//   win_done   : window closed and buffer drained
//   overflow   : sticky, a hit was dropped on a full buffer
module spad_hit_collector
  import spad_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,             // power of two, >= 2
  parameter int unsigned CNT_W      = CNT_W_DEFAULT  // <= HIT_TIME_W
) (
  input  logic             clk_250M,
  input  logic             rst_auto,
  input  logic             TDC_start,
  input  logic             trig,
  input  logic             time_gate,
  input  logic [15:0]      spad_int,
  input  logic             hit_ready,
  output logic             hit_valid,
  output logic [CNT_W-1:0] hit_time,
  output logic [15:0]      hit_int,
  output logic [1:0]       hit_idx,
  output logic             win_done,
  output logic             overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = FIFO_DEPTH[PtrW:0];
  // All-ones end of window; equals WIN_LAST at the default width.
  localparam logic [CNT_W-1:0] CntLast = {CNT_W{1'b1}};

  // Synchronizers and rising-edge detection
  logic start_s, trig_s, gate_s;
  logic start_q, trig_q, gate_q;
  logic start_rise, trig_rise, gate_rise;

  spad_sync2 u_sync_start (
    .clk_250M (clk_250M),
    .rst_auto (rst_auto),
    .din      (TDC_start),
    .dout     (start_s)
  );

  spad_sync2 u_sync_trig (
    .clk_250M (clk_250M),
    .rst_auto (rst_auto),
    .din      (trig),
    .dout     (trig_s)
  );

  spad_sync2 u_sync_gate (
    .clk_250M (clk_250M),
    .rst_auto (rst_auto),
    .din      (time_gate),
    .dout     (gate_s)
  );

  assign start_rise = start_s & ~start_q;
  assign trig_rise  = trig_s & ~trig_q;
  assign gate_rise  = gate_s & ~gate_q;

  // FSM and coarse counter
  spad_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arm;

  // Capture pipeline: the edge is time-stamped when seen, spad_int is taken one cycle later.
  logic             gate_cap, trig_cap, capture;
  logic [1:0]       nhit_q;
  logic             pend_q;
  logic [CNT_W-1:0] pend_time_q;
  logic [1:0]       pend_idx_q;

  // Buffer
  hit_rec_t        mem_q [FIFO_DEPTH];
  hit_rec_t        push_rec, head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            full, push, pop, drop;
  logic            overflow_q;
  logic            unused_head_time;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d = StArmed;
          cnt_d   = '0;
        end
      end
      StArmed: begin
        // Counter stops at the last count; no wrap.
        if (cnt_q == CntLast) begin
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // A capture seen in the last armed cycle is still in flight in pend_q.
        if (count_q == '0 && !pend_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign arm      = (state_q == StIdle) && start_rise;
  assign gate_cap = (state_q == StArmed) && gate_rise;
  // Recovery record only when the window has seen no photon; a coincident gate edge wins.
  assign trig_cap = (state_q == StArmed) && trig_rise && !gate_rise && (nhit_q == 2'd0);
  assign capture  = gate_cap | trig_cap;

  assign full = (count_q == FullCnt);
  assign pop  = hit_valid & hit_ready;
  assign push = pend_q & (~full | pop);
  assign drop = pend_q & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    push_rec           = '0;
    push_rec.time_cnt  = HIT_TIME_W'(pend_time_q);
    push_rec.intensity = spad_int;
    push_rec.idx       = pend_idx_q;
  end

  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      start_q     <= 1'b0;
      trig_q      <= 1'b0;
      gate_q      <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      nhit_q      <= 2'd0;
      pend_q      <= 1'b0;
      pend_time_q <= '0;
      pend_idx_q  <= 2'd0;
    end else begin
      start_q <= start_s;
      trig_q  <= trig_s;
      gate_q  <= gate_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= capture;
      if (capture) begin
        pend_time_q <= cnt_q;
        pend_idx_q  <= nhit_q;
      end
      // Ordinal counts every captured photon, including ones later dropped.
      if (arm) begin
        nhit_q <= 2'd0;
      end else if (capture && nhit_q != 2'd3) begin
        nhit_q <= nhit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count_q is non-zero.
  always_ff @(posedge clk_250M) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign unused_head_time = ^head.time_cnt;

  assign hit_valid = (count_q != '0);
  assign hit_time  = hit_valid ? head.time_cnt[CNT_W-1:0] : '0;
  assign hit_int   = hit_valid ? head.intensity : 16'd0;
  assign hit_idx   = hit_valid ? head.idx : 2'd0;
  assign win_done  = (state_q == StDone);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_spad_hit_collector.sv
module tb_spad_hit_collector;
  import spad_pkg::*;

  localparam int Depth  = 4;
  localparam int WinLen = WIN_LAST + 1;

  logic        clk_250M = 1'b0;
  logic        rst_auto = 1'b0;
  logic        TDC_start, trig, time_gate, hit_ready;
  logic [15:0] spad_int;
  logic        hit_valid, win_done, overflow;
  logic [8:0]  hit_time;
  logic [15:0] hit_int;
  logic [1:0]  hit_idx;

  always #2 clk_250M = ~clk_250M;

  spad_hit_collector #(
    .FIFO_DEPTH (Depth),
    .CNT_W      (CNT_W_DEFAULT)
  ) dut (
    .clk_250M  (clk_250M),
    .rst_auto  (rst_auto),
    .TDC_start (TDC_start),
    .trig      (trig),
    .time_gate (time_gate),
    .spad_int  (spad_int),
    .hit_ready (hit_ready),
    .hit_valid (hit_valid),
    .hit_time  (hit_time),
    .hit_int   (hit_int),
    .hit_idx   (hit_idx),
    .win_done  (win_done),
    .overflow  (overflow)
  );

  typedef struct {
    int t;
    int val;
    int idx;
  } rec_t;

  typedef struct {
    int   cyc;
    rec_t r;
  } sched_t;

  // Model: records expected in the buffer, records scheduled to arrive, records consumed.
  rec_t   mq[$];
  sched_t sq[$];
  rec_t   got[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     exp_ovf, exp_done, model_on;
  bit     armed;
  int     k_start, nhits;

  always @(posedge clk_250M) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_near(input string name, input int act, input int req, input int tol);
    checks++;
    if (act < req - tol || act > req + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d (cycle %0d)", name, act, req, tol, cyc);
    end
  endtask

  // Per-cycle compare, then advance the model by what this cycle's edge will do.
  always @(negedge clk_250M) begin
    int     sz;
    bit     pop, push;
    rec_t   r;
    sched_t s;
    if (!rst_auto && model_on) begin
      sz = mq.size();
      check("hit_valid", int'(hit_valid), int'(sz > 0));
      if (sz > 0 && hit_valid) begin
        check("hit_time", int'(hit_time), mq[0].t);
        check("hit_int", int'(hit_int), mq[0].val);
        check("hit_idx", int'(hit_idx), mq[0].idx);
      end
      check("overflow", int'(overflow), int'(exp_ovf));
      check("win_done", int'(win_done), int'(exp_done));
      if (hit_valid && hit_ready) begin
        r.t = int'(hit_time);
        r.val = int'(hit_int);
        r.idx = int'(hit_idx);
        got.push_back(r);
      end
      pop  = (sz > 0) && hit_ready;
      push = (sq.size() > 0) && (sq[0].cyc == cyc);
      if (armed && cyc >= k_start + WinLen + 3 && sz == 0 && !push) exp_done = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) begin
        s = sq.pop_front();
        if (sz == Depth && !pop) exp_ovf = 1'b1;
        else mq.push_back(s.r);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_250M);
      #1;
    end
  endtask

  task automatic schedule(input int t, input int val, input int idx);
    sched_t s;
    s.cyc   = cyc + 3;
    s.r.t   = t;
    s.r.val = val;
    s.r.idx = idx;
    sq.push_back(s);
  endtask

  task automatic do_reset();
    rst_auto  = 1'b1;
    TDC_start = 1'b0;
    trig      = 1'b0;
    time_gate = 1'b0;
    mq.delete();
    sq.delete();
    got.delete();
    exp_ovf  = 1'b0;
    exp_done = 1'b0;
    armed    = 1'b0;
    nhits    = 0;
    #1;
    check("rst_hit_valid", int'(hit_valid), 0);
    check("rst_hit_time", int'(hit_time), 0);
    check("rst_hit_int", int'(hit_int), 0);
    check("rst_hit_idx", int'(hit_idx), 0);
    check("rst_win_done", int'(win_done), 0);
    check("rst_overflow", int'(overflow), 0);
    tick(2);
    rst_auto = 1'b0;
  endtask

  task automatic start_win();
    TDC_start = 1'b1;
    k_start   = cyc;
    armed     = 1'b1;
    nhits     = 0;
    got.delete();
  endtask

  // A photon counts if its synchronized edge lands on coarse count 0..WIN_LAST.
  task automatic photon(input logic [15:0] val);
    int t;
    spad_int  = val;
    time_gate = 1'b1;
    t = cyc - k_start - 1;
    if (armed && t >= 0 && t < WinLen) begin
      schedule(t, int'(val), (nhits > 3) ? 3 : nhits);
      nhits++;
    end
    tick();
    time_gate = 1'b0;
  endtask

  task automatic trig_rise();
    int t;
    trig = 1'b1;
    t = cyc - k_start - 1;
    if (armed && t >= 0 && t < WinLen && nhits == 0) begin
      schedule(t, int'(spad_int), 0);
      nhits = 1;
    end
  endtask

  task automatic wait_done(input int bound);
    int i;
    i = 0;
    while (!exp_done && i < bound) begin
      tick();
      i++;
    end
    check("window_done", int'(win_done), 1);
  endtask

  task automatic rand_window(input int mode);
    bit trig_done;
    int action;
    trig_done = 1'b0;
    hit_ready = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      photon(16'($urandom));
      tick($urandom_range(3, 8));
    end
    start_win();
    tick($urandom_range(1, 5));
    while (cyc < k_start + WinLen + 28) begin
      case (mode)
        0:       hit_ready = 1'b1;
        1:       hit_ready = 1'($urandom_range(0, 1));
        default: hit_ready = ($urandom_range(0, 7) == 0);
      endcase
      action = $urandom_range(0, 9);
      if (action < 4) begin
        photon(16'($urandom));
        tick($urandom_range(3, 12));
      end else if (action == 4 && !trig_done) begin
        trig_rise();
        trig_done = 1'b1;
        tick(4);
      end else if (action == 5) begin
        TDC_start = ~TDC_start;
        tick(3);
      end else begin
        tick($urandom_range(1, 20));
      end
    end
    hit_ready = 1'b1;
    wait_done(300);
    do_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    model_on  = 1'b1;
    hit_ready = 1'b0;
    spad_int  = 16'h0000;
    do_reset();

    // Three photons at 100/300/900 ns, consumer always ready.
    hit_ready = 1'b1;
    start_win();
    tick(25);
    photon(16'h1111);
    tick(k_start + 75 - cyc);
    photon(16'h2222);
    tick(k_start + 225 - cyc);
    photon(16'h3333);
    wait_done(1000);
    check("t1_count", got.size(), 3);
    if (got.size() == 3) begin
      check_near("t1_time0", got[0].t, 25, 1);
      check_near("t1_time1", got[1].t, 75, 1);
      check_near("t1_time2", got[2].t, 225, 1);
      check("t1_idx0", got[0].idx, 0);
      check("t1_idx1", got[1].idx, 1);
      check("t1_idx2", got[2].idx, 2);
      check("t1_int2", got[2].val, 32'h3333);
    end
    do_reset();

    // Five photons 40 ns apart into a stalled consumer: fifth dropped.
    hit_ready = 1'b0;
    start_win();
    tick(10);
    for (int i = 0; i < 5; i++) begin
      photon(16'h0A00 + 16'(i));
      tick(9);
    end
    check("t2_overflow", int'(overflow), 1);
    check("t2_valid", int'(hit_valid), 1);
    check("t2_head_idx", int'(hit_idx), 0);
    check("t2_head_int", int'(hit_int), 32'h0A00);
    check_near("t2_head_time", int'(hit_time), 10, 1);
    tick(20);
    check("t2_hold_int", int'(hit_int), 32'h0A00);
    check("t2_hold_idx", int'(hit_idx), 0);
    hit_ready = 1'b1;
    wait_done(1000);
    check("t2_count", got.size(), 4);
    if (got.size() == 4) check("t2_last_int", got[3].val, 32'h0A03);
    do_reset();

    // Full buffer, fifth push coincides with a pop: both accepted.
    hit_ready = 1'b0;
    start_win();
    tick(10);
    for (int i = 0; i < 4; i++) begin
      photon(16'h0B00 + 16'(i));
      tick(5);
    end
    photon(16'h0B04);
    tick(2);
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    tick(5);
    check("t3_overflow", int'(overflow), 0);
    check("t3_head_int", int'(hit_int), 32'h0B01);
    hit_ready = 1'b1;
    wait_done(1000);
    check("t3_count", got.size(), 5);
    if (got.size() == 5) begin
      check("t3_last_int", got[4].val, 32'h0B04);
      check("t3_last_idx", got[4].idx, 3);
    end
    do_reset();

    // Reset mid-window with two hits buffered.
    hit_ready = 1'b0;
    start_win();
    tick(5);
    photon(16'h0C00);
    tick(5);
    photon(16'h0C01);
    tick(6);
    check("t4_valid_before", int'(hit_valid), 1);
    do_reset();
    photon(16'h0C02);
    tick(10);
    check("t4_valid_after", int'(hit_valid), 0);
    check("t4_done_after", int'(win_done), 0);
    do_reset();

    // Trig with no gate: one recovery record.
    hit_ready = 1'b0;
    start_win();
    tick(20);
    spad_int = 16'hBEEF;
    trig_rise();
    tick(10);
    check("t5_valid", int'(hit_valid), 1);
    check("t5_idx", int'(hit_idx), 0);
    check("t5_int", int'(hit_int), 32'hBEEF);
    check_near("t5_time", int'(hit_time), 20, 1);
    hit_ready = 1'b1;
    wait_done(1000);
    check("t5_count", got.size(), 1);
    do_reset();

    // Photons before start and after the window end are ignored.
    hit_ready = 1'b1;
    photon(16'h0D00);
    tick(4);
    start_win();
    tick(WinLen + 18);
    photon(16'h0D01);
    wait_done(100);
    tick(10);
    check("t6_count", got.size(), 0);
    do_reset();

    for (int w = 0; w < 6; w++) rand_window(w % 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
